// File: rtl/step_pulse_gen.sv
// Button/switch conditioner: synchronises and debounces a push-button and a slide switch,
// producing a one-clock press strobe and a debounced switch level for the downstream FSM.
module step_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       sw_raw,
    output logic       pulse,
    output logic       in_db,
    output logic       btn_db,
    output logic [1:0] bstate
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARM    = 2'b01,
        HELD   = 2'b10,
        DISARM = 2'b11
    } bstate_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_m, btn_s;
    logic             sw_m, sw_s;
    bstate_t          state, state_next;
    logic [CNT_W-1:0] bcnt, bcnt_next;
    logic             pulse_next;
    logic [CNT_W-1:0] scnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            sw_m  <= 1'b0;
            sw_s  <= 1'b0;
        end else begin
            btn_m <= btn_raw;
            btn_s <= btn_m;
            sw_m  <= sw_raw;
            sw_s  <= sw_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            bcnt  <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_next;
            bcnt  <= bcnt_next;
            pulse <= pulse_next;
        end
    end

    always_comb begin
        state_next = state;
        bcnt_next  = bcnt;
        pulse_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn_s) begin
                    state_next = ARM;
                    bcnt_next  = '0;
                end
            end
            ARM: begin
                if (!btn_s) begin
                    state_next = IDLE;
                    bcnt_next  = '0;
                end else if (bcnt == LAST) begin
                    state_next = HELD;
                    pulse_next = 1'b1;
                end else begin
                    bcnt_next = bcnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_next = DISARM;
                    bcnt_next  = '0;
                end
            end
            DISARM: begin
                // A bounce back to 1 during release re-enters HELD without a new strobe.
                if (btn_s) begin
                    state_next = HELD;
                end else if (bcnt == LAST) begin
                    state_next = IDLE;
                end else begin
                    bcnt_next = bcnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign btn_db = state[1];
    assign bstate = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scnt  <= '0;
            in_db <= 1'b0;
        end else if (sw_s == in_db) begin
            scnt <= '0;
        end else if (scnt == LAST) begin
            in_db <= sw_s;
            scnt  <= '0;
        end else begin
            scnt <= scnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen with DEBOUNCE_CYCLES=8: stimulus queues expected
// output events (edge number + value); a monitor pops and checks on every output change.
module tb_step_pulse_gen;

    localparam int unsigned D = 8;

    typedef struct {
        int unsigned cyc;
        logic        val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_raw = 1'b0;
    logic       sw_raw = 1'b0;
    logic       pulse, in_db, btn_db;
    logic [1:0] bstate;

    int unsigned edge_n = 0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    int unsigned base;

    ev_t pulse_q[$];
    ev_t btn_q[$];
    ev_t sw_q[$];

    step_pulse_gen #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .pulse(pulse), .in_db(in_db), .btn_db(btn_db), .bstate(bstate)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic match(input string name, inout ev_t q[$], input logic val);
        ev_t e;
        n_chk++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected change to %0b at edge %0d, expected none", name, val, edge_n);
        end else begin
            e = q.pop_front();
            if (e.cyc != edge_n || e.val != val) begin
                n_fail++;
                $display("FAIL %s: got %0b at edge %0d, expected %0b at edge %0d",
                         name, val, edge_n, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: samples #1 after each rising edge and reports every output event.
    logic prev_btn = 1'b0, prev_sw = 1'b0;
    always @(posedge clk) begin
        edge_n++;
        #1;
        if (pulse === 1'b1) match("pulse", pulse_q, 1'b1);
        if (btn_db !== prev_btn) match("btn_db", btn_q, btn_db);
        if (in_db !== prev_sw) match("in_db", sw_q, in_db);
        prev_btn = btn_db;
        prev_sw  = in_db;
    end

    task automatic cycles(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cycles(3);
        check("reset_pulse", pulse, 0);
        check("reset_btn_db", btn_db, 0);
        check("reset_in_db", in_db, 0);
        check("reset_bstate", bstate, 0);
        reset = 1'b1;
        cycles(2);

        // 1: steady press
        btn_raw = 1'b1;
        base = edge_n;
        pulse_q.push_back('{base + 11, 1'b1});
        btn_q.push_back('{base + 11, 1'b1});
        cycles(40);
        check("t1_bstate_held", bstate, 2);

        // 2: steady release
        btn_raw = 1'b0;
        base = edge_n;
        btn_q.push_back('{base + 11, 1'b0});
        cycles(3);
        check("t2_bstate_disarm", bstate, 3);
        cycles(17);
        check("t2_bstate_idle", bstate, 0);

        // 3: bouncing press, then steady
        for (int i = 0; i < 10; i++) begin
            btn_raw = (i % 2 == 0);
            cycles(3);
        end
        btn_raw = 1'b1;
        base = edge_n;
        pulse_q.push_back('{base + 11, 1'b1});
        btn_q.push_back('{base + 11, 1'b1});
        cycles(20);

        // 4: short release glitch while held
        btn_raw = 1'b0;
        cycles(4);
        btn_raw = 1'b1;
        cycles(20);
        check("t4_bstate_held", bstate, 2);
        check("t4_btn_db", btn_db, 1);
        btn_raw = 1'b0;
        base = edge_n;
        btn_q.push_back('{base + 11, 1'b0});
        cycles(20);

        // 5: switch set, glitch ignored, then cleared
        sw_raw = 1'b1;
        base = edge_n;
        sw_q.push_back('{base + 10, 1'b1});
        cycles(20);
        sw_raw = 1'b0;
        cycles(5);
        sw_raw = 1'b1;
        cycles(20);
        check("t5_in_db_held", in_db, 1);
        sw_raw = 1'b0;
        base = edge_n;
        sw_q.push_back('{base + 10, 1'b0});
        cycles(20);

        // 6: reset mid-count in ARM (bcnt=5 after edge base+8)
        btn_raw = 1'b1;
        base = edge_n;
        cycles(8);
        check("t6_bstate_arm", bstate, 1);
        reset = 1'b0;
        #1;
        check("t6_rst_bstate", bstate, 0);
        check("t6_rst_pulse", pulse, 0);
        check("t6_rst_btn_db", btn_db, 0);
        btn_raw = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(30);
        check("t6_bstate_idle", bstate, 0);

        check("pending_events", pulse_q.size() + btn_q.size() + sw_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
